// File: rtl/dht11_leitor.sv
// DHT11 single-wire reader: issues the host start pulse, decodes the 40-bit
// answer by high-phase width and presents the five sensor bytes plus a checksum flag.
module dht11_leitor #(
   parameter int unsigned TICKS_PER_US  = 50,
   parameter int unsigned START_LOW_US  = 18000,
   parameter int unsigned BIT_THRESH_US = 40,
   parameter int unsigned TIMEOUT_US    = 200
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   inout  wire        dht_data,
   output logic       busy,
   output logic       data_valid,
   output logic       timeout,
   output logic       crc_ok,
   output logic [7:0] HUM_INT,
   output logic [7:0] HUM_FLOAT,
   output logic [7:0] TEMP_INT,
   output logic [7:0] TEMP_FLOAT,
   output logic [7:0] CRC
);

   localparam logic [31:0] START_CYC   = 32'(START_LOW_US * TICKS_PER_US);
   localparam logic [31:0] THRESH_CYC  = 32'(BIT_THRESH_US * TICKS_PER_US);
   localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * TICKS_PER_US);

   typedef enum logic [3:0] {
      IDLE,
      START_LOW,
      RELEASE,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      DONE,
      ERROR
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] phase_cnt;
   logic [5:0]  bit_cnt;
   logic [38:0] shift_reg;
   logic        sync_a;
   logic        sync_b;
   logic        sync_prev;
   logic        drive_low;
   logic        edge_rise;
   logic        edge_fall;
   logic        bit_val;
   logic        phase_expired;
   logic [39:0] frame_next;
   logic [7:0]  sum_next;

   assign dht_data = drive_low ? 1'b0 : 1'bz;

   assign edge_rise     = sync_b & ~sync_prev;
   assign edge_fall     = ~sync_b & sync_prev;
   assign bit_val       = (phase_cnt > THRESH_CYC);
   assign phase_expired = (phase_cnt >= TIMEOUT_CYC - 32'd1);
   assign frame_next    = {shift_reg, bit_val};
   assign sum_next      = frame_next[39:32] + frame_next[31:24] +
                          frame_next[23:16] + frame_next[15:8];

   // Synchronizer idles high so the pulled-up line never fakes an edge after reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_a    <= 1'b1;
         sync_b    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_a    <= dht_data;
         sync_b    <= sync_a;
         sync_prev <= sync_b;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (start) state_next = START_LOW;
         START_LOW: if (phase_cnt >= START_CYC - 32'd1) state_next = RELEASE;
         RELEASE: begin
            if (edge_fall)          state_next = RESP_LOW;
            else if (phase_expired) state_next = ERROR;
         end
         RESP_LOW: begin
            if (edge_rise)          state_next = RESP_HIGH;
            else if (phase_expired) state_next = ERROR;
         end
         RESP_HIGH: begin
            if (edge_fall)          state_next = BIT_LOW;
            else if (phase_expired) state_next = ERROR;
         end
         BIT_LOW: begin
            if (edge_rise)          state_next = BIT_HIGH;
            else if (phase_expired) state_next = ERROR;
         end
         BIT_HIGH: begin
            if (edge_fall)          state_next = (bit_cnt == 6'd39) ? DONE : BIT_LOW;
            else if (phase_expired) state_next = ERROR;
         end
         DONE:      state_next = IDLE;
         ERROR:     state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      drive_low  = 1'b0;
      busy       = 1'b0;
      data_valid = 1'b0;
      timeout    = 1'b0;
      case (state)
         START_LOW: begin
            drive_low = 1'b1;
            busy      = 1'b1;
         end
         RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: busy = 1'b1;
         DONE:    data_valid = 1'b1;
         ERROR:   timeout    = 1'b1;
         default: ;
      endcase
   end

   // Phase counter restarts on every state change so each phase is timed alone
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_cnt <= '0;
      end else if (state_next != state) begin
         phase_cnt <= '0;
      end else if (state != IDLE) begin
         phase_cnt <= phase_cnt + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (state == RESP_HIGH && edge_fall) begin
         bit_cnt <= '0;
      end else if (state == BIT_HIGH && edge_fall) begin
         bit_cnt   <= bit_cnt + 6'd1;
         shift_reg <= frame_next[38:0];
      end
   end

   // Bytes are captured on entry to DONE so they are already valid during the pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         HUM_INT    <= '0;
         HUM_FLOAT  <= '0;
         TEMP_INT   <= '0;
         TEMP_FLOAT <= '0;
         CRC        <= '0;
         crc_ok     <= 1'b0;
      end else if (state_next == DONE && state != DONE) begin
         HUM_INT    <= frame_next[39:32];
         HUM_FLOAT  <= frame_next[31:24];
         TEMP_INT   <= frame_next[23:16];
         TEMP_FLOAT <= frame_next[15:8];
         CRC        <= frame_next[7:0];
         crc_ok     <= (sum_next == frame_next[7:0]);
      end
   end

endmodule

// File: tb/tb_dht11_leitor.sv
// Directed bench for dht11_leitor: a behavioural DHT11 answers on the pulled-up
// line, and the decoded bytes, flags and timing are compared with hand-computed values.
`timescale 1ns/1ps
module tb_dht11_leitor;

   localparam int TICKS    = 2;
   localparam int START_US = 20;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       sensorLow = 1'b0;
   wire        dht_data;
   logic       busy;
   logic       data_valid;
   logic       timeout;
   logic       crc_ok;
   logic [7:0] HUM_INT;
   logic [7:0] HUM_FLOAT;
   logic [7:0] TEMP_INT;
   logic [7:0] TEMP_FLOAT;
   logic [7:0] CRC;

   int checks = 0;
   int passed = 0;
   int dvCount = 0;
   int toCount = 0;
   logic busyAtDv = 1'b1;

   pullup (dht_data);
   assign dht_data = sensorLow ? 1'b0 : 1'bz;

   dht11_leitor #(
      .TICKS_PER_US (TICKS),
      .START_LOW_US (START_US),
      .BIT_THRESH_US(40),
      .TIMEOUT_US   (200)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .dht_data  (dht_data),
      .busy      (busy),
      .data_valid(data_valid),
      .timeout   (timeout),
      .crc_ok    (crc_ok),
      .HUM_INT   (HUM_INT),
      .HUM_FLOAT (HUM_FLOAT),
      .TEMP_INT  (TEMP_INT),
      .TEMP_FLOAT(TEMP_FLOAT),
      .CRC       (CRC)
   );

   // 2 MHz clock: one microsecond is exactly two cycles
   always #250 clock = ~clock;

   always @(negedge clock) begin
      if (data_valid) begin
         dvCount  = dvCount + 1;
         busyAtDv = busy;
      end
      if (timeout) toCount = toCount + 1;
   end

   initial begin
      #60_000_000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passed++;
      else $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic waitUs(input int us);
      repeat (us * TICKS) @(negedge clock);
   endtask

   task automatic waitLine(input logic level, input int maxCycles, input string tag);
      int n = 0;
      while (dht_data !== level && n < maxCycles) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, {31'd0, dht_data === level}, 32'd1);
   endtask

   task automatic pulseStart();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   // Behavioural sensor: answers the host, then sends nbits bits MSB first
   task automatic sensorModel(input logic [39:0] frame, input int hi0, input int hi1,
                              input int nbits);
      waitLine(1'b0, 20, "host_drives_low");
      waitLine(1'b1, START_US * TICKS + 20, "host_releases");
      waitUs(30);
      sensorLow = 1'b1; waitUs(80);
      sensorLow = 1'b0; waitUs(80);
      for (int i = 0; i < nbits; i++) begin
         sensorLow = 1'b1; waitUs(50);
         sensorLow = 1'b0; waitUs(frame[39 - i] ? hi1 : hi0);
      end
      sensorLow = 1'b1; waitUs(50);
      sensorLow = 1'b0;
   endtask

   task automatic applyStimulus(input logic [39:0] frame, input int hi0, input int hi1,
                                input int nbits);
      pulseStart();
      sensorModel(frame, hi0, hi1, nbits);
   endtask

   task automatic checkFrame(input logic [7:0] h, input logic [7:0] hf, input logic [7:0] t,
                             input logic [7:0] tf, input logic [7:0] c, input logic ok,
                             input int dvBefore);
      repeat (10) @(negedge clock);
      checkOutput("dv_pulses", dvCount - dvBefore, 1);
      checkOutput("busy_at_dv", {31'd0, busyAtDv}, 0);
      checkOutput("HUM_INT", {24'd0, HUM_INT}, {24'd0, h});
      checkOutput("HUM_FLOAT", {24'd0, HUM_FLOAT}, {24'd0, hf});
      checkOutput("TEMP_INT", {24'd0, TEMP_INT}, {24'd0, t});
      checkOutput("TEMP_FLOAT", {24'd0, TEMP_FLOAT}, {24'd0, tf});
      checkOutput("CRC", {24'd0, CRC}, {24'd0, c});
      checkOutput("crc_ok", {31'd0, crc_ok}, {31'd0, ok});
      checkOutput("busy_idle", {31'd0, busy}, 0);
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "_line"}, {31'd0, dht_data}, 1);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
      checkOutput({tag, "_dv"}, {31'd0, data_valid}, 0);
      checkOutput({tag, "_timeout"}, {31'd0, timeout}, 0);
      checkOutput({tag, "_crc_ok"}, {31'd0, crc_ok}, 0);
      checkOutput({tag, "_bytes"}, {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, 0);
      checkOutput({tag, "_CRC"}, {24'd0, CRC}, 0);
   endtask

   initial begin
      int dvBefore;
      int toBefore;
      int k;
      logic lineDropped;

      repeat (5) @(negedge clock);
      checkCleared("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // Nominal frame 35,0,24,5 with matching checksum
      dvBefore = dvCount;
      applyStimulus({8'd35, 8'd0, 8'd24, 8'd5, 8'd64}, 26, 70, 40);
      checkFrame(8'd35, 8'd0, 8'd24, 8'd5, 8'd64, 1'b1, dvBefore);

      // Same data, wrong checksum: bytes still latched
      dvBefore = dvCount;
      applyStimulus({8'd35, 8'd0, 8'd24, 8'd5, 8'd65}, 26, 70, 40);
      checkFrame(8'd35, 8'd0, 8'd24, 8'd5, 8'd65, 1'b0, dvBefore);

      // 200+100 wraps to 44
      dvBefore = dvCount;
      applyStimulus({8'd200, 8'd100, 8'd0, 8'd0, 8'd44}, 26, 70, 40);
      checkFrame(8'd200, 8'd100, 8'd0, 8'd0, 8'd44, 1'b1, dvBefore);

      // High phases just either side of the 40 us threshold
      dvBefore = dvCount;
      applyStimulus({8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hE0}, 39, 41, 40);
      checkFrame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hE0, 1'b1, dvBefore);

      // Silent sensor: abort 200 us after release, extra start ignored
      dvBefore = dvCount;
      toBefore = toCount;
      pulseStart();
      waitLine(1'b0, 20, "silent_host_low");
      waitLine(1'b1, START_US * TICKS + 20, "silent_host_release");
      k = 0;
      while (!timeout && k < 1000) begin
         @(negedge clock);
         k++;
         if (k == 50) start = 1'b1;
         if (k == 51) start = 1'b0;
      end
      checkOutput("timeout_cycles", k, 400);
      checkOutput("timeout_busy", {31'd0, busy}, 0);
      checkOutput("timeout_HUM_INT", {24'd0, HUM_INT}, 32'hA5);
      checkOutput("timeout_CRC", {24'd0, CRC}, 32'hE0);
      checkOutput("timeout_crc_ok", {31'd0, crc_ok}, 1);
      lineDropped = 1'b0;
      repeat (200) begin
         @(negedge clock);
         if (dht_data !== 1'b1 || busy) lineDropped = 1'b1;
      end
      checkOutput("single_transaction", {31'd0, lineDropped}, 0);
      checkOutput("timeout_pulses", toCount - toBefore, 1);
      checkOutput("timeout_no_dv", dvCount - dvBefore, 0);

      // Reset while the host drives the start pulse
      pulseStart();
      repeat (10) @(negedge clock);
      checkOutput("start_low_driven", {31'd0, dht_data}, 0);
      reset_n = 1'b0;
      #1;
      checkOutput("reset_releases_line", {31'd0, dht_data}, 1);
      @(negedge clock) reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // Reset during bit 20 discards the partial frame
      dvBefore = dvCount;
      applyStimulus({8'd55, 8'd10, 8'd27, 8'd3, 8'd95}, 26, 70, 20);
      repeat (10) @(negedge clock);
      checkOutput("mid_frame_busy", {31'd0, busy}, 1);
      reset_n = 1'b0;
      #1;
      checkCleared("midreset");
      checkOutput("midreset_no_dv", dvCount - dvBefore, 0);
      @(negedge clock) reset_n = 1'b1;
      repeat (5) @(negedge clock);

      dvBefore = dvCount;
      applyStimulus({8'd55, 8'd10, 8'd27, 8'd3, 8'd95}, 26, 70, 40);
      checkFrame(8'd55, 8'd10, 8'd27, 8'd3, 8'd95, 1'b1, dvBefore);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
